// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow sequencer for the pong datapath.
// Owns the pong block's reset and frame-strobe gate, drives puck and paddle
// speeds, and tracks score and lives from hit/miss pulses. Single clock domain.
//
// Ports:
//   pixel_clk_in      pixel clock
//   rst_in            synchronous active-high reset
//   nf_in             one-cycle new-frame strobe
//   start_in          debounced start button level
//   hit_in            one-cycle paddle-hit event
//   miss_in           one-cycle puck-lost event
//   game_rst_out      reset to pong datapath
//   run_out           frame-strobe gate (pong nf = nf_in & run_out)
//   puck_speed_out    puck speed
//   paddle_speed_out  paddle speed, always min(puck_speed+1,15)
//   lives_out         lives remaining
//   score_out         hits this game, saturating at 255
//   state_out         IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 PAUSE=5
//
// Optional feature macro: PONG_PAUSE_EN enables start-button pause in PLAY.
module pong_game_ctrl #(
   parameter int unsigned LIVES        = 3,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned OVER_FRAMES  = 120,
   parameter int unsigned SPEEDUP_HITS = 4,
   parameter int unsigned INIT_SPEED   = 1,
   parameter int unsigned MAX_SPEED    = 15
) (
   input  logic       pixel_clk_in,
   input  logic       rst_in,
   input  logic       nf_in,
   input  logic       start_in,
   input  logic       hit_in,
   input  logic       miss_in,
   output logic       game_rst_out,
   output logic       run_out,
   output logic [3:0] puck_speed_out,
   output logic [3:0] paddle_speed_out,
   output logic [1:0] lives_out,
   output logic [7:0] score_out,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      MISS  = 3'd3,
      OVER  = 3'd4,
      PAUSE = 3'd5
   } state_t;

   localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
   localparam int unsigned FCW        = $clog2(MAX_FRAMES + 1);
   localparam int unsigned HCW        = $clog2(SPEEDUP_HITS + 1);

   localparam logic [3:0]     INIT_SPD   = 4'(INIT_SPEED);
   localparam logic [3:0]     MAX_SPD    = 4'(MAX_SPEED);
   localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
   localparam logic [FCW-1:0] SERVE_LAST = FCW'(SERVE_FRAMES - 1);
   localparam logic [FCW-1:0] OVER_LAST  = FCW'(OVER_FRAMES - 1);
   localparam logic [HCW-1:0] HITS_WRAP  = HCW'(SPEEDUP_HITS);

   // Paddle always runs one step faster than the puck, capped at 15.
   function automatic logic [3:0] paddle_of(input logic [3:0] speed);
      return (speed == 4'hF) ? 4'hF : speed + 4'd1;
   endfunction

   state_t         state_q, state_d;
   logic [FCW-1:0] frame_q, frame_d;
   logic [HCW-1:0] hit_q,   hit_d;
   logic [3:0]     speed_q, speed_d;
   logic [3:0]     paddle_q, paddle_d;
   logic [1:0]     lives_q, lives_d;
   logic [7:0]     score_q, score_d;
   logic           grst_q,  grst_d;
   logic           run_q,   run_d;
   logic           start_q;
   logic           start_rise;

   // State and output registers.
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         frame_q  <= '0;
         hit_q    <= '0;
         speed_q  <= INIT_SPD;
         paddle_q <= paddle_of(INIT_SPD);
         lives_q  <= LIVES_INIT;
         score_q  <= '0;
         grst_q   <= 1'b1;
         run_q    <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         hit_q    <= hit_d;
         speed_q  <= speed_d;
         paddle_q <= paddle_d;
         lives_q  <= lives_d;
         score_q  <= score_d;
         grst_q   <= grst_d;
         run_q    <= run_d;
         start_q  <= start_in;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      hit_d      = hit_q;
      speed_d    = speed_q;
      lives_d    = lives_q;
      score_d    = score_q;
      grst_d     = 1'b1;
      run_d      = 1'b0;
      start_rise = start_in & ~start_q;

      case (state_q)
         IDLE: begin
            if (start_rise) state_d = SERVE;
         end

         SERVE: begin
            if (nf_in) begin
               if (frame_q == SERVE_LAST) begin
                  state_d = PLAY;
                  frame_d = '0;
               end else begin
                  frame_d = frame_q + FCW'(1);
               end
            end
         end

         PLAY: begin
            // A miss takes priority over a simultaneous hit or start press.
            if (miss_in) begin
               if (lives_q > 2'd1) begin
                  lives_d = lives_q - 2'd1;
                  state_d = MISS;
               end else begin
                  lives_d = 2'd0;
                  state_d = OVER;
                  frame_d = '0;
               end
            end else begin
               if (hit_in) begin
                  if (score_q != 8'hFF) score_d = score_q + 8'd1;
                  if (hit_q + HCW'(1) == HITS_WRAP) begin
                     hit_d = '0;
                     if (speed_q < MAX_SPD) speed_d = speed_q + 4'd1;
                  end else begin
                     hit_d = hit_q + HCW'(1);
                  end
               end
`ifdef PONG_PAUSE_EN
               if (start_rise) state_d = PAUSE;
`endif
            end
         end

         MISS: begin
            if (nf_in) begin
               state_d = SERVE;
               frame_d = '0;
            end
         end

         OVER: begin
            // Start press or final frame both return to IDLE.
            if (start_rise) begin
               state_d = IDLE;
            end else if (nf_in) begin
               if (frame_q == OVER_LAST) state_d = IDLE;
               else                      frame_d = frame_q + FCW'(1);
            end
         end

`ifdef PONG_PAUSE_EN
         PAUSE: begin
            if (start_rise) state_d = PLAY;
         end
`endif

         default: state_d = IDLE;
      endcase

      // Entering or sitting in IDLE reloads the game settings.
      if (state_d == IDLE) begin
         lives_d = LIVES_INIT;
         score_d = '0;
         speed_d = INIT_SPD;
         hit_d   = '0;
         frame_d = '0;
      end

      case (state_d)
         PLAY:    begin grst_d = 1'b0; run_d = 1'b1; end
         OVER:    begin grst_d = 1'b0; run_d = 1'b0; end
         PAUSE:   begin grst_d = 1'b0; run_d = 1'b0; end
         default: begin grst_d = 1'b1; run_d = 1'b0; end
      endcase

      paddle_d = paddle_of(speed_d);
   end

   assign game_rst_out     = grst_q;
   assign run_out          = run_q;
   assign puck_speed_out   = speed_q;
   assign paddle_speed_out = paddle_q;
   assign lives_out        = lives_q;
   assign score_out        = score_q;
   assign state_out        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. Two instances share stimulus: one with
// MAX_SPEED=15 and one with MAX_SPEED=2 to observe speed saturation.
module tb_pong_game_ctrl;

   logic       clk;
   logic       rst;
   logic       nf;
   logic       start;
   logic       hit;
   logic       miss;

   logic       grst, run;
   logic [3:0] puck, paddle;
   logic [1:0] lives;
   logic [7:0] score;
   logic [2:0] state;

   logic       s_grst, s_run;
   logic [3:0] s_puck, s_paddle;
   logic [1:0] s_lives;
   logic [7:0] s_score;
   logic [2:0] s_state;

   int n_cmp = 0;
   int n_err = 0;

   pong_game_ctrl #(
      .LIVES(3), .SERVE_FRAMES(2), .OVER_FRAMES(3),
      .SPEEDUP_HITS(4), .INIT_SPEED(1), .MAX_SPEED(15)
   ) dut (
      .pixel_clk_in(clk), .rst_in(rst), .nf_in(nf), .start_in(start),
      .hit_in(hit), .miss_in(miss),
      .game_rst_out(grst), .run_out(run), .puck_speed_out(puck),
      .paddle_speed_out(paddle), .lives_out(lives), .score_out(score),
      .state_out(state)
   );

   pong_game_ctrl #(
      .LIVES(3), .SERVE_FRAMES(2), .OVER_FRAMES(3),
      .SPEEDUP_HITS(4), .INIT_SPEED(1), .MAX_SPEED(2)
   ) dut_sat (
      .pixel_clk_in(clk), .rst_in(rst), .nf_in(nf), .start_in(start),
      .hit_in(hit), .miss_in(miss),
      .game_rst_out(s_grst), .run_out(s_run), .puck_speed_out(s_puck),
      .paddle_speed_out(s_paddle), .lives_out(s_lives), .score_out(s_score),
      .state_out(s_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_nf();
      nf = 1'b1; tick(); nf = 1'b0; tick();
   endtask

   task automatic pulse_hit();
      hit = 1'b1; tick(); hit = 1'b0; tick();
   endtask

   task automatic pulse_miss();
      miss = 1'b1; tick(); miss = 1'b0; tick();
   endtask

   task automatic press_start();
      start = 1'b1; tick(); start = 1'b0; tick();
   endtask

   initial begin
      rst = 1'b1; nf = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
      tick(); tick();

      // Reset values
      chk("rst_state",  32'(state),  32'd0);
      chk("rst_grst",   32'(grst),   32'd1);
      chk("rst_run",    32'(run),    32'd0);
      chk("rst_puck",   32'(puck),   32'd1);
      chk("rst_paddle", 32'(paddle), 32'd2);
      chk("rst_lives",  32'(lives),  32'd3);
      chk("rst_score",  32'(score),  32'd0);
      rst = 1'b0;
      tick();
      chk("idle_hold", 32'(state), 32'd0);

      // Start held high: one transition into SERVE
      start = 1'b1;
      tick();
      chk("start_serve", 32'(state), 32'd1);
      repeat (9) tick();
      chk("start_held_state", 32'(state), 32'd1);
      chk("serve_lives",      32'(lives), 32'd3);
      chk("serve_score",      32'(score), 32'd0);
      chk("serve_grst",       32'(grst),  32'd1);
      chk("serve_run",        32'(run),   32'd0);
      start = 1'b0;
      tick();

      // Serve countdown: two frames
      pulse_nf();
      chk("serve_one_nf", 32'(state), 32'd1);
      pulse_nf();
      chk("play_state", 32'(state), 32'd2);
      chk("play_run",   32'(run),   32'd1);
      chk("play_grst",  32'(grst),  32'd0);

      // Eight hits: two speed-ups
      repeat (8) pulse_hit();
      chk("hits_score",   32'(score),    32'd8);
      chk("hits_puck",    32'(puck),     32'd3);
      chk("hits_paddle",  32'(paddle),   32'd4);
      chk("sat_puck",     32'(s_puck),   32'd2);
      chk("sat_paddle",   32'(s_paddle), 32'd3);
      chk("sat_score",    32'(s_score),  32'd8);

`ifdef PONG_PAUSE_EN
      start = 1'b1; tick();
      chk("pause_state", 32'(state), 32'd5);
      chk("pause_run",   32'(run),   32'd0);
      chk("pause_grst",  32'(grst),  32'd0);
      start = 1'b0; tick();
      pulse_hit();
      chk("pause_hit_ignored", 32'(score), 32'd8);
      pulse_miss();
      chk("pause_miss_lives", 32'(lives), 32'd3);
      chk("pause_miss_state", 32'(state), 32'd5);
      start = 1'b1; tick();
      chk("resume_state", 32'(state), 32'd2);
      chk("resume_run",   32'(run),   32'd1);
      start = 1'b0; tick();
`else
      start = 1'b1; tick();
      chk("play_start_ignored", 32'(state), 32'd2);
      chk("play_start_run",     32'(run),   32'd1);
      start = 1'b0; tick();
`endif

      // Hit and miss together: the miss wins
      hit = 1'b1; miss = 1'b1; tick(); hit = 1'b0; miss = 1'b0;
      chk("hm_lives", 32'(lives), 32'd2);
      chk("hm_score", 32'(score), 32'd8);
      chk("hm_state", 32'(state), 32'd3);
      chk("hm_grst",  32'(grst),  32'd1);
      chk("hm_run",   32'(run),   32'd0);
      tick();
      pulse_hit();
      chk("miss_hit_ignored", 32'(score), 32'd8);
      pulse_nf();
      chk("miss_to_serve", 32'(state), 32'd1);
      chk("miss_speed_kept", 32'(puck), 32'd3);
      pulse_nf();
      chk("serve2_one_nf", 32'(state), 32'd1);
      pulse_nf();
      chk("serve2_play", 32'(state), 32'd2);

      // Discarded hit must not have advanced the hit counter
      repeat (3) pulse_hit();
      chk("hc_score3", 32'(score), 32'd11);
      chk("hc_puck3",  32'(puck),  32'd3);
      pulse_hit();
      chk("hc_score4",  32'(score),  32'd12);
      chk("hc_puck4",   32'(puck),   32'd4);
      chk("hc_paddle4", 32'(paddle), 32'd5);

      // Second miss, then last miss into OVER
      pulse_miss();
      chk("miss2_lives", 32'(lives), 32'd1);
      chk("miss2_state", 32'(state), 32'd3);
      repeat (3) pulse_nf();
      chk("miss2_play", 32'(state), 32'd2);
      pulse_miss();
      chk("over_state", 32'(state), 32'd4);
      chk("over_lives", 32'(lives), 32'd0);
      chk("over_grst",  32'(grst),  32'd0);
      chk("over_run",   32'(run),   32'd0);
      pulse_hit();
      chk("over_hit_ignored", 32'(score), 32'd12);
      pulse_nf();
      pulse_nf();
      chk("over_two_nf", 32'(state), 32'd4);
      pulse_nf();
      chk("over_to_idle",  32'(state),  32'd0);
      chk("idle_lives",    32'(lives),  32'd3);
      chk("idle_score",    32'(score),  32'd0);
      chk("idle_puck",     32'(puck),   32'd1);
      chk("idle_paddle",   32'(paddle), 32'd2);
      chk("idle_grst",     32'(grst),   32'd1);

      // Repeat run: leave OVER with start press
      press_start();
      chk("rerun_serve", 32'(state), 32'd1);
      pulse_nf(); pulse_nf();
      pulse_miss();
      repeat (3) pulse_nf();
      pulse_miss();
      repeat (3) pulse_nf();
      pulse_miss();
      chk("rerun_over", 32'(state), 32'd4);
      start = 1'b1; tick();
      chk("over_start_idle", 32'(state), 32'd0);
      chk("over_start_grst", 32'(grst),  32'd1);
      start = 1'b0; tick();

      // Reset mid-game
      press_start();
      pulse_nf(); pulse_nf();
      pulse_hit();
      chk("mid_score", 32'(score), 32'd1);
`ifdef PONG_PAUSE_EN
      start = 1'b1; tick(); start = 1'b0;
      chk("mid_pause", 32'(state), 32'd5);
`endif
      rst = 1'b1; tick();
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_score", 32'(score), 32'd0);
      chk("midrst_lives", 32'(lives), 32'd3);
      chk("midrst_puck",  32'(puck),  32'd1);
      chk("midrst_grst",  32'(grst),  32'd1);
      chk("midrst_run",   32'(run),   32'd0);
      rst = 1'b0; tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
